coin_count_ctrl: RTL and testbench

Sequencing controller for the coin counter datapath. It accepts single-cycle coin events, keeps a saturating cent total and handles purchase requests against a fixed price. It drives the 7-bit value input of the two-digit BCD/7-segment display driver; that driver's own gt99 output flags totals above 99. One clock domain, from the board clock.

---
 rtl/coin_count_ctrl.sv | 130 +++++++++++++
 tb/tb_coin_count_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_count_ctrl.sv
// Coin counter sequencing controller: saturating cent total, coin count and purchase handshake.
// Define COIN_BLINK_EN to blink the display (disp_blank) while the total exceeds 99.
module coin_count_ctrl #(
    parameter logic [6:0]  PRICE     = 7'd35,
    parameter logic [6:0]  MAX_TOTAL = 7'd127,
    parameter logic [23:0] BLINK_DIV = 24'd12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       buy_req,
    input  logic       clear,
    output logic       ready,
    output logic [6:0] total,
    output logic [7:0] coin_cnt,
    output logic       vend_ack,
    output logic       vend_nak,
    output logic       sat_flag,
    output logic       disp_blank
);

    typedef enum logic [2:0] {IDLE, ADD, CHECK, VEND, REFUSE} state_t;

    state_t     state;
    logic [4:0] coin_val;
    logic [7:0] sum;

    function automatic logic [4:0] coin_value(input logic [1:0] kind);
        case (kind)
            2'b00:   return 5'd1;
            2'b01:   return 5'd5;
            2'b10:   return 5'd10;
            default: return 5'd25;
        endcase
    endfunction

    // One bit wider than total so an overflowing add is visible before clipping.
    assign sum = {1'b0, total} + {3'b000, coin_val};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            total    <= '0;
            coin_cnt <= '0;
            coin_val <= '0;
            vend_ack <= 1'b0;
            vend_nak <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking assignment in this block wins.
            vend_ack <= 1'b0;
            vend_nak <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                ready    <= 1'b1;
                total    <= '0;
                coin_cnt <= '0;
                sat_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (coin_valid) begin
                            coin_val <= coin_value(coin_type);
                            state    <= ADD;
                            ready    <= 1'b0;
                        end else if (buy_req) begin
                            state <= CHECK;
                            ready <= 1'b0;
                        end
                    end
                    ADD: begin
                        if (sum > {1'b0, MAX_TOTAL}) begin
                            total    <= MAX_TOTAL;
                            sat_flag <= 1'b1;
                        end else begin
                            total <= sum[6:0];
                        end
                        if (coin_cnt != 8'hFF) coin_cnt <= coin_cnt + 8'd1;
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                    CHECK: begin
                        state <= (total >= PRICE) ? VEND : REFUSE;
                    end
                    VEND: begin
                        total    <= total - PRICE;
                        vend_ack <= 1'b1;
                        state    <= IDLE;
                        ready    <= 1'b1;
                    end
                    REFUSE: begin
                        vend_nak <= 1'b1;
                        state    <= IDLE;
                        ready    <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef COIN_BLINK_EN
    logic [23:0] blink_div;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            blink_div  <= '0;
            disp_blank <= 1'b0;
        end else if (total > 7'd99) begin
            if (blink_div == BLINK_DIV - 24'd1) begin
                blink_div  <= '0;
                disp_blank <= ~disp_blank;
            end else begin
                blink_div <= blink_div + 24'd1;
            end
        end else begin
            blink_div  <= '0;
            disp_blank <= 1'b0;
        end
    end
`else
    assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_coin_count_ctrl.sv
// Scoreboard bench for coin_count_ctrl: driver pushes expected results, monitor pops on each completion.
module tb_coin_count_ctrl;

    localparam int PRICE     = 35;
    localparam int MAX_TOTAL = 127;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       buy_req = 1'b0;
    logic       clear = 1'b0;
    logic       ready;
    logic [6:0] total;
    logic [7:0] coin_cnt;
    logic       vend_ack;
    logic       vend_nak;
    logic       sat_flag;
    logic       disp_blank;

    always #5 clk = ~clk;

    coin_count_ctrl #(
        .PRICE(7'd35),
        .MAX_TOTAL(7'd127),
        .BLINK_DIV(24'd4)
    ) dut (
        .CLOCK_50(clk),
        .reset_n(reset_n),
        .coin_valid(coin_valid),
        .coin_type(coin_type),
        .buy_req(buy_req),
        .clear(clear),
        .ready(ready),
        .total(total),
        .coin_cnt(coin_cnt),
        .vend_ack(vend_ack),
        .vend_nak(vend_nak),
        .sat_flag(sat_flag),
        .disp_blank(disp_blank)
    );

    typedef struct {
        bit ack;
        bit nak;
        int total;
        int cnt;
        bit sat;
    } exp_t;

    typedef enum int {OP_COIN, OP_BUY, OP_BOTH, OP_NOISE, OP_CLR_IDLE, OP_CLR_CHECK} op_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_total = 0;
    int   m_cnt = 0;
    bit   m_sat = 1'b0;
    logic prev_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cents(input logic [1:0] kind);
        case (kind)
            2'b00:   return 1;
            2'b01:   return 5;
            2'b10:   return 10;
            default: return 25;
        endcase
    endfunction

    task automatic push_exp(input bit ack, input bit nak);
        exp_t e;
        e.ack = ack; e.nak = nak; e.total = m_total; e.cnt = m_cnt; e.sat = m_sat;
        exp_q.push_back(e);
    endtask

    task automatic model_coin(input logic [1:0] kind);
        int s;
        s = m_total + cents(kind);
        if (s > MAX_TOTAL) begin
            m_total = MAX_TOTAL;
            m_sat   = 1'b1;
        end else begin
            m_total = s;
        end
        if (m_cnt < 255) m_cnt++;
        push_exp(1'b0, 1'b0);
    endtask

    task automatic model_buy();
        if (m_total >= PRICE) begin
            m_total -= PRICE;
            push_exp(1'b1, 1'b0);
        end else begin
            push_exp(1'b0, 1'b1);
        end
    endtask

    task automatic model_clear();
        m_total = 0;
        m_cnt   = 0;
        m_sat   = 1'b0;
    endtask

    // Monitor: a rising ready marks a finished transaction; otherwise no pulse may appear.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ready && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("vend_ack", vend_ack, e.ack);
                        check("vend_nak", vend_nak, e.nak);
                        check("total", total, e.total);
                        check("coin_cnt", coin_cnt, e.cnt);
                        check("sat_flag", sat_flag, e.sat);
`ifndef COIN_BLINK_EN
                        check("disp_blank_tied", disp_blank, 0);
`endif
                    end
                end else begin
                    check("no_stray_pulse", {vend_ack, vend_nak}, 0);
                end
            end
            prev_ready = ready;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input op_t kind, input logic [1:0] ct);
        coin_type = ct;
        case (kind)
            OP_COIN, OP_NOISE: begin model_coin(ct); coin_valid = 1'b1; end
            OP_BOTH:           begin model_coin(ct); coin_valid = 1'b1; buy_req = 1'b1; end
            OP_BUY:            begin model_buy(); buy_req = 1'b1; end
            OP_CLR_CHECK:      begin model_clear(); push_exp(1'b0, 1'b0); buy_req = 1'b1; end
            default:           begin model_clear(); clear = 1'b1; coin_valid = 1'($urandom_range(0, 1)); end
        endcase
        @(posedge clk); #1;
        coin_valid = 1'b0; buy_req = 1'b0; clear = 1'b0;
        if (kind == OP_NOISE) begin
            coin_valid = 1'b1; buy_req = 1'b1; coin_type = ~ct;
            @(posedge clk); #1;
            coin_valid = 1'b0; buy_req = 1'b0;
        end
        if (kind == OP_CLR_CHECK) begin
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
        end
        if (kind == OP_CLR_IDLE) begin
            check("clear_total", total, 0);
            check("clear_cnt", coin_cnt, 0);
            check("clear_sat", sat_flag, 0);
            check("clear_ready", ready, 1);
        end
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("ready_after_reset", ready, 1);
        check("total_after_reset", total, 0);
        run_op(OP_COIN, 2'b11);

        // Asynchronous reset in the middle of an ADD.
        coin_valid = 1'b1; coin_type = 2'b10;
        @(posedge clk); #2;
        coin_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_total", total, 0);
        check("rst_cnt", coin_cnt, 0);
        check("rst_ack_nak", {vend_ack, vend_nak}, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_blank", disp_blank, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1 check("ready_after_release", ready, 1);
        model_clear();
        @(posedge clk); #1;

        // 25+25+10+1 = 61, then buy -> 26 with latency check, then refused buy.
        run_op(OP_COIN, 2'b11);
        run_op(OP_COIN, 2'b11);
        run_op(OP_COIN, 2'b10);
        run_op(OP_COIN, 2'b00);
        model_buy();
        buy_req = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            buy_req = 1'b0;
            lat++;
        end while (!vend_ack && lat < 6);
        check("ack_latency_edges", lat, 3);
        @(posedge clk); #1;
        check("ack_width", vend_ack, 0);
        run_op(OP_BUY, 2'b00);

        // Saturation from 120, then buy -> 92 with sat_flag sticky.
        run_op(OP_CLR_IDLE, 2'b00);
        repeat (4) run_op(OP_COIN, 2'b11);
        repeat (2) run_op(OP_COIN, 2'b10);
        run_op(OP_COIN, 2'b11);
        run_op(OP_BUY, 2'b00);

        // Collisions and clear during CHECK.
        run_op(OP_BOTH, 2'b01);
        run_op(OP_NOISE, 2'b10);
        run_op(OP_CLR_CHECK, 2'b00);

        // Coin count ceiling.
        for (int i = 0; i < 258; i++) run_op(OP_COIN, 2'b00);

`ifdef COIN_BLINK_EN
        begin
            int   tog[$];
            logic prevb;
            run_op(OP_CLR_IDLE, 2'b00);
            repeat (4) run_op(OP_COIN, 2'b11);
            run_op(OP_COIN, 2'b10);
            @(negedge clk);
            prevb = disp_blank;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (disp_blank !== prevb) tog.push_back(i);
                prevb = disp_blank;
            end
            check("blink_toggle_count", tog.size() >= 4, 1);
            for (int k = 1; k < tog.size(); k++) check("blink_period", tog[k] - tog[k-1], 4);
            @(posedge clk); #1;
            run_op(OP_BUY, 2'b00);
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                check("blank_low_after_buy", disp_blank, 0);
            end
        end
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] ct;
            r  = $urandom_range(0, 9);
            ct = 2'($urandom_range(0, 3));
            case (r)
                0, 1, 2, 3: run_op(OP_COIN, ct);
                4, 5:       run_op(OP_BUY, ct);
                6:          run_op(OP_BOTH, ct);
                7:          run_op(OP_NOISE, ct);
                8:          run_op(OP_CLR_CHECK, ct);
                default:    run_op(OP_CLR_IDLE, ct);
            endcase
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
